// File: rtl/pos_frame_tx_pkg.sv
// Shared definitions for the position-frame link (transmit and receive sides).
// Holds the frame length, the default sync byte, the FSM state encoding and
// helper functions that build frame bytes and the frame checksum.
package pos_frame_tx_pkg;

    localparam int         FRAME_LEN      = 6;
    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
    localparam logic [2:0] LAST_IDX       = 3'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } tx_state_e;

    // Checksum over the four coordinate bytes; the header is not covered.
    // Upper coordinate bytes carry only bits 9:8, the rest are zero.
    function automatic logic [7:0] frame_chk(input logic [9:0] x, input logic [9:0] y);
        frame_chk = {6'b000000, x[9:8]} ^ x[7:0] ^ {6'b000000, y[9:8]} ^ y[7:0];
    endfunction

    // Byte at position idx of a frame: HEADER, X hi, X lo, Y hi, Y lo, CHK.
    function automatic logic [7:0] frame_byte(input logic [2:0] idx,
                                              input logic [7:0] header,
                                              input logic [9:0] x,
                                              input logic [9:0] y,
                                              input logic [7:0] chk);
        case (idx)
            3'd0:    frame_byte = header;
            3'd1:    frame_byte = {6'b000000, x[9:8]};
            3'd2:    frame_byte = x[7:0];
            3'd3:    frame_byte = {6'b000000, y[9:8]};
            3'd4:    frame_byte = y[7:0];
            3'd5:    frame_byte = chk;
            default: frame_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/mod_m_counter.sv
// Free-running modulo-M counter with a terminal-count tick.
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset (count -> 0)
//   srst     - synchronous reset (count -> 0)
//   max_tick - high for the one cycle in which the count equals M-1
module mod_m_counter #(
    parameter int M = 10,
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic srst,
    output logic max_tick
);

    logic [N-1:0] count_r;

    // Count 0..M-1 and wrap back to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {N{1'b0}};
        end else if (srst) begin
            count_r <= {N{1'b0}};
        end else if (count_r == N'(M - 1)) begin
            count_r <= {N{1'b0}};
        end else begin
            count_r <= count_r + N'(1);
        end
    end

    assign max_tick = (count_r == N'(M - 1));

endmodule

// File: rtl/pos_frame_tx.sv
// Periodic transmitter of the own-tank position frame over a byte UART.
// Every PERIOD cycles it snapshots X/Y and sends six bytes
// (HEADER, X hi, X lo, Y hi, Y lo, CHK), one tx_start per tx_done_tick.
// Ports:
//   clk          - rising-edge clock
//   rst          - asynchronous active-low reset, release synchronised internally
//   x_pos_in     - 10-bit X position, sampled at frame launch
//   y_pos_in     - 10-bit Y position, sampled at frame launch
//   tx_done_tick - UART byte-complete pulse
//   tx_start     - one-cycle send request for tx_data
//   tx_data      - byte being sent, held until its tx_done_tick
//   busy         - frame in flight
//   frame_done   - one-cycle pulse after the last byte completes
module pos_frame_tx
    import pos_frame_tx_pkg::*;
#(
    parameter int         PERIOD     = 1666667,
    parameter int         PERIOD_BIT = 21,
    parameter logic [7:0] HEADER     = HEADER_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] x_pos_in,
    input  logic [9:0] y_pos_in,
    input  logic       tx_done_tick,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       frame_done
);

    logic [1:0] rst_sync_r;
    logic       rst_sync_n_s;
    logic       tick_s;
    tx_state_e  state_r;
    logic [2:0] idx_r;
    logic [2:0] next_idx_s;
    logic [7:0] next_byte_s;
    logic [9:0] x_snap_r;
    logic [9:0] y_snap_r;
    logic [7:0] chk_r;
    logic       tx_start_r;
    logic [7:0] tx_data_r;
    logic       busy_r;
    logic       frame_done_r;

    // Reset synchroniser: assertion is immediate, release is seen two edges later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_sync_n_s = rst_sync_r[1];

    mod_m_counter #(
        .M (PERIOD),
        .N (PERIOD_BIT)
    ) u_period (
        .clk      (clk),
        .rst_n    (rst_sync_n_s),
        .srst     (1'b0),
        .max_tick (tick_s)
    );

    assign next_idx_s  = idx_r + 3'd1;
    assign next_byte_s = frame_byte(next_idx_s, HEADER, x_snap_r, y_snap_r, chk_r);

    // Frame sequencer; every output is a register updated here.
    always_ff @(posedge clk or negedge rst_sync_n_s) begin
        if (!rst_sync_n_s) begin
            state_r      <= ST_IDLE;
            idx_r        <= 3'd0;
            x_snap_r     <= 10'd0;
            y_snap_r     <= 10'd0;
            chk_r        <= 8'h00;
            tx_start_r   <= 1'b0;
            tx_data_r    <= 8'h00;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            tx_start_r   <= 1'b0;
            frame_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // A tick landing in the frame_done cycle is dropped, not queued.
                    if (tick_s && !frame_done_r) begin
                        x_snap_r   <= x_pos_in;
                        y_snap_r   <= y_pos_in;
                        chk_r      <= frame_chk(x_pos_in, y_pos_in);
                        idx_r      <= 3'd0;
                        tx_data_r  <= HEADER;
                        tx_start_r <= 1'b1;
                        busy_r     <= 1'b1;
                        state_r    <= ST_START;
                    end else begin
                        busy_r     <= 1'b0;
                    end
                end
                ST_START: begin
                    // tx_done_tick here belongs to no outstanding byte; ignore it.
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tx_done_tick) begin
                        if (idx_r == LAST_IDX) begin
                            frame_done_r <= 1'b1;
                            busy_r       <= 1'b0;
                            state_r      <= ST_IDLE;
                        end else begin
                            idx_r      <= next_idx_s;
                            tx_data_r  <= next_byte_s;
                            tx_start_r <= 1'b1;
                            state_r    <= ST_START;
                        end
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                default: begin
                    idx_r   <= 3'd0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_start   = tx_start_r;
    assign tx_data    = tx_data_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_pos_frame_tx.sv
// Self-checking bench for pos_frame_tx with a short period (50 cycles).
// Edges are numbered from the first rising edge after reset release (edge 1);
// ticks fall in the cycle after edges 1+50j (j>=1), so an idle transmitter
// shows tx_start after edge 2+50j.
module tb_pos_frame_tx;

    localparam int PERIOD = 50;

    logic       clk          = 1'b0;
    logic       rst          = 1'b0;
    logic [9:0] x_pos_in     = 10'd0;
    logic [9:0] y_pos_in     = 10'd0;
    logic       tx_done_tick = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;
    logic       frame_done;

    int checks   = 0;
    int passed   = 0;
    int edge_cnt = 0;

    typedef struct {
        logic [9:0]      x;
        logic [9:0]      y;
        int              d;        // done delay for bytes 0..4
        int              l;        // done delay for byte 5
        bit              chg;      // zero the inputs during byte 2
        bit              sp_start; // spurious tx_done_tick in the START cycle
        bit              sp_idle;  // spurious tx_done_tick while idle
        logic [5:0][7:0] exp;      // exp[5] is the first byte on the line
    } vec_t;

    pos_frame_tx #(
        .PERIOD     (PERIOD),
        .PERIOD_BIT (6),
        .HEADER     (8'hA5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .x_pos_in     (x_pos_in),
        .y_pos_in     (y_pos_in),
        .tx_done_tick (tx_done_tick),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) edge_cnt <= 0;
        else      edge_cnt <= edge_cnt + 1;
    end

    function automatic vec_t mk(input logic [9:0] x, input logic [9:0] y, input int d,
                                input int l, input bit chg, input bit sp_start,
                                input bit sp_idle, input logic [47:0] bytes);
        vec_t v;
        v.x = x; v.y = y; v.d = d; v.l = l;
        v.chg = chg; v.sp_start = sp_start; v.sp_idle = sp_idle;
        v.exp = bytes;
        return v;
    endfunction

    // Edge at which the next tx_start is due, given the frame_done edge f.
    function automatic int next_start(input int f);
        return 1 + PERIOD * ((f - 1) / PERIOD + 1) + 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    endtask

    task automatic wait_start(input int exp_edge, input bit sp_idle, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (sp_idle) begin
                tx_done_tick = (i == 3);
                if (i == 5) chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
            end
            if (tx_start === 1'b1) seen = 1'b1;
        end
        tx_done_tick = 1'b0;
        if (!seen) chk({tag, "_start_timeout"}, 32'd0, 32'd1);
        else       chk({tag, "_start_edge"}, edge_cnt, exp_edge);
    endtask

    task automatic send_bytes(input vec_t v, input int stop_k, input string tag, output int f_edge);
        int d;
        f_edge = 0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin
                @(negedge clk);
                tx_done_tick = 1'b0;
                chk({tag, "_tx_start"}, {31'd0, tx_start}, 32'd1);
            end
            chk({tag, "_tx_data"}, {24'd0, tx_data}, {24'd0, v.exp[5-k]});
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            if (k == stop_k) return;
            if (k == 0 && v.sp_start) tx_done_tick = 1'b1;
            d = (k == 5) ? v.l : v.d;
            for (int w = 1; w <= d; w++) begin
                @(negedge clk);
                tx_done_tick = (w == d);
                chk({tag, "_start_low"}, {31'd0, tx_start}, 32'd0);
                chk({tag, "_data_hold"}, {24'd0, tx_data}, {24'd0, v.exp[5-k]});
                if (v.chg && k == 2 && w == 1) begin
                    x_pos_in = 10'd0;
                    y_pos_in = 10'd0;
                end
            end
        end
        @(negedge clk);
        tx_done_tick = 1'b0;
        f_edge = edge_cnt;
        chk({tag, "_frame_done"}, {31'd0, frame_done}, 32'd1);
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        chk({tag, "_no_start"}, {31'd0, tx_start}, 32'd0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'd0, frame_done}, 32'd0);
    endtask

    initial begin
        vec_t tbl[7];
        int   exp_start;
        int   f;

        tbl[0] = mk(10'h155, 10'h0F0, 3,  3, 1'b0, 1'b0, 1'b0, {8'hA5, 8'h01, 8'h55, 8'h00, 8'hF0, 8'hA4});
        tbl[1] = mk(10'h3FF, 10'h3FF, 3,  3, 1'b1, 1'b0, 1'b0, {8'hA5, 8'h03, 8'hFF, 8'h03, 8'hFF, 8'h00});
        tbl[2] = mk(10'h000, 10'h000, 20, 20, 1'b0, 1'b0, 1'b0, {8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
        // Last-byte delay 28 makes frame_done coincide with the tick at edge 351.
        tbl[3] = mk(10'h2AA, 10'h155, 3,  28, 1'b0, 1'b0, 1'b0, {8'hA5, 8'h02, 8'hAA, 8'h01, 8'h55, 8'hFC});
        tbl[4] = mk(10'h0F0, 10'h155, 2,  2, 1'b0, 1'b1, 1'b1, {8'hA5, 8'h00, 8'hF0, 8'h01, 8'h55, 8'hA4});
        tbl[5] = mk(10'h001, 10'h002, 3,  3, 1'b0, 1'b0, 1'b0, {8'hA5, 8'h00, 8'h01, 8'h00, 8'h02, 8'h03});
        tbl[6] = mk(10'h200, 10'h0FF, 3,  3, 1'b0, 1'b0, 1'b0, {8'hA5, 8'h02, 8'h00, 8'h00, 8'hFF, 8'hFD});

        // Power-on reset state.
        repeat (3) @(negedge clk);
        chk("rst_tx_start",   {31'd0, tx_start},   32'd0);
        chk("rst_tx_data",    {24'd0, tx_data},    32'd0);
        chk("rst_busy",       {31'd0, busy},       32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        rst = 1'b1;
        exp_start = PERIOD + 2;

        for (int i = 0; i < 5; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            x_pos_in = tbl[i].x;
            y_pos_in = tbl[i].y;
            wait_start(exp_start, tbl[i].sp_idle, tag);
            send_bytes(tbl[i], -1, tag, f);
            exp_start = next_start(f);
        end

        // Reset in the middle of byte 3.
        x_pos_in = tbl[5].x;
        y_pos_in = tbl[5].y;
        wait_start(exp_start, 1'b0, "midrst");
        send_bytes(tbl[5], 3, "midrst", f);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_tx_start",   {31'd0, tx_start},   32'd0);
        chk("midrst_tx_data",    {24'd0, tx_data},    32'd0);
        chk("midrst_busy",       {31'd0, busy},       32'd0);
        chk("midrst_frame_done", {31'd0, frame_done}, 32'd0);
        x_pos_in = tbl[6].x;
        y_pos_in = tbl[6].y;
        repeat (2) @(negedge clk);
        chk("midrst_hold_busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        wait_start(PERIOD + 2, 1'b0, "postrst");
        send_bytes(tbl[6], -1, "postrst", f);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
